// File: rtl/gcd_arb_pkg.sv
// Shared types and helpers for the GCD engine request arbiter.
package gcd_arb_pkg;

    // Arbiter sequencing states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_BUSY  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // Timer width: wide enough to hold TIMEOUT_CYC-1 with one spare bit
    function automatic int unsigned tmr_width(input int unsigned timeout_cyc);
        return $clog2(timeout_cyc) + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant_c,
    output logic [ID_W-1:0]  id_c,
    output logic             any_c
);

    // Scan requesters starting at the pointer; first hit wins
    always_comb begin
        logic [ID_W-1:0] idx;
        grant_c = '0;
        id_c    = '0;
        any_c   = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = ID_W'((32'(ptr) + k) % N_REQ);
            if (!any_c && req[idx]) begin
                any_c        = 1'b1;
                grant_c[idx] = 1'b1;
                id_c         = idx;
            end
        end
    end

endmodule

// File: rtl/gcd_req_arbiter.sv
// Shares one extended-GCD engine among N_REQ requesters with timeout/flush recovery.
module gcd_req_arbiter
    import gcd_arb_pkg::*;
#(
    parameter int unsigned NBITS       = 2048,
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned ID_W        = 2,
    parameter int unsigned TIMEOUT_CYC = 16384
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*NBITS-1:0]   x_in,
    input  logic [N_REQ*NBITS-1:0]   y_in,
    output logic [N_REQ-1:0]         ack,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ID_W-1:0]          res_id,
    output logic [NBITS+2:0]         res_a,
    output logic [NBITS+2:0]         res_b,
    output logic [NBITS-1:0]         res_gcd,
    output logic                     res_err,
    output logic                     busy,
    output logic                     core_enable_p,
    output logic [NBITS-1:0]         core_x,
    output logic [NBITS-1:0]         core_y,
    input  logic [NBITS+2:0]         core_a,
    input  logic [NBITS+2:0]         core_b,
    input  logic [NBITS-1:0]         core_gcd,
    input  logic                     core_done_p
);

    localparam int unsigned CW    = NBITS + 3;
    localparam int unsigned TMR_W = tmr_width(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

    state_t             state, state_nx;
    logic [ID_W-1:0]    ptr, ptr_nx;
    logic [TMR_W-1:0]   timer, timer_nx;
    logic               zero_q, zero_nx;
    logic [N_REQ-1:0]   ack_nx;
    logic               res_valid_nx;
    logic [ID_W-1:0]    res_id_nx;
    logic [CW-1:0]      res_a_nx, res_b_nx;
    logic [NBITS-1:0]   res_gcd_nx;
    logic               res_err_nx;
    logic               busy_nx;
    logic               en_nx;
    logic [NBITS-1:0]   core_x_nx, core_y_nx;

    logic [N_REQ-1:0]   arb_grant;
    logic [ID_W-1:0]    arb_id;
    logic               arb_any;
    logic [NBITS-1:0]   sel_x, sel_y;
    logic               sel_zero;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req     (req),
        .ptr     (ptr),
        .grant_c (arb_grant),
        .id_c    (arb_id),
        .any_c   (arb_any)
    );

    // Operand mux for the granted requester
    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_x = x_in[i*NBITS +: NBITS];
                sel_y = y_in[i*NBITS +: NBITS];
            end
        end
        sel_zero = (sel_x == '0) || (sel_y == '0);
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx     = state;
        ptr_nx       = ptr;
        timer_nx     = timer;
        zero_nx      = zero_q;
        ack_nx       = '0;
        en_nx        = 1'b0;
        res_valid_nx = res_valid;
        res_id_nx    = res_id;
        res_a_nx     = res_a;
        res_b_nx     = res_b;
        res_gcd_nx   = res_gcd;
        res_err_nx   = res_err;
        core_x_nx    = core_x;
        core_y_nx    = core_y;

        unique case (state)
            ST_IDLE: begin
                if (arb_any) begin
                    ack_nx    = arb_grant;
                    core_x_nx = sel_x;
                    core_y_nx = sel_y;
                    res_id_nx = arb_id;
                    ptr_nx    = (arb_id == ID_LAST) ? '0 : arb_id + ID_W'(1);
                    zero_nx   = sel_zero;
                    // Start pulse coincides with the ack cycle; zero operands never start the engine
                    en_nx     = !sel_zero;
                    state_nx  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                timer_nx = '0;
                if (zero_q) begin
                    res_a_nx     = '0;
                    res_b_nx     = '0;
                    res_gcd_nx   = '0;
                    res_err_nx   = 1'b1;
                    res_valid_nx = 1'b1;
                    state_nx     = ST_RESP;
                end else begin
                    state_nx = ST_BUSY;
                end
            end
            ST_BUSY: begin
                timer_nx = timer + TMR_W'(1);
                if (core_done_p) begin
                    res_a_nx     = core_a;
                    res_b_nx     = core_b;
                    res_gcd_nx   = core_gcd;
                    res_err_nx   = 1'b0;
                    res_valid_nx = 1'b1;
                    state_nx     = ST_RESP;
                end else if (timer == TMR_LAST) begin
                    res_a_nx   = '0;
                    res_b_nx   = '0;
                    res_gcd_nx = '0;
                    res_err_nx = 1'b1;
                    timer_nx   = '0;
                    core_x_nx  = NBITS'(1);
                    core_y_nx  = NBITS'(1);
                    en_nx      = 1'b1;
                    state_nx   = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                timer_nx = timer + TMR_W'(1);
                // A done seen during the restart pulse belongs to the aborted run
                if ((core_done_p && !core_enable_p) || (timer == TMR_LAST)) begin
                    res_valid_nx = 1'b1;
                    state_nx     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (res_valid && res_ready) begin
                    res_valid_nx = 1'b0;
                    state_nx     = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        busy_nx = (state_nx != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            timer         <= '0;
            zero_q        <= 1'b0;
            ack           <= '0;
            res_valid     <= 1'b0;
            res_id        <= '0;
            res_a         <= '0;
            res_b         <= '0;
            res_gcd       <= '0;
            res_err       <= 1'b0;
            busy          <= 1'b0;
            core_enable_p <= 1'b0;
            core_x        <= '0;
            core_y        <= '0;
        end else begin
            state         <= state_nx;
            ptr           <= ptr_nx;
            timer         <= timer_nx;
            zero_q        <= zero_nx;
            ack           <= ack_nx;
            res_valid     <= res_valid_nx;
            res_id        <= res_id_nx;
            res_a         <= res_a_nx;
            res_b         <= res_b_nx;
            res_gcd       <= res_gcd_nx;
            res_err       <= res_err_nx;
            busy          <= busy_nx;
            core_enable_p <= en_nx;
            core_x        <= core_x_nx;
            core_y        <= core_y_nx;
        end
    end

endmodule

// File: tb/tb_gcd_req_arbiter.sv
// Self-checking bench for gcd_req_arbiter with a behavioural extended-GCD engine.
module tb_gcd_req_arbiter;

    localparam int NB   = 16;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int TO   = 72;
    localparam int CW   = NB + 3;
    localparam int WAIT_BUDGET = 600;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ*NB-1:0]   x_in, y_in;
    logic [NREQ-1:0]      ack;
    logic                 res_valid, res_ready;
    logic [IDW-1:0]       res_id;
    logic [CW-1:0]        res_a, res_b;
    logic [NB-1:0]        res_gcd;
    logic                 res_err, busy, core_enable_p;
    logic [NB-1:0]        core_x, core_y;
    logic [CW-1:0]        core_a = '0, core_b = '0;
    logic [NB-1:0]        core_gcd = '0;
    logic                 core_done_p = 1'b0;

    gcd_req_arbiter #(
        .NBITS(NB), .N_REQ(NREQ), .ID_W(IDW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .x_in(x_in), .y_in(y_in), .ack(ack),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_a(res_a), .res_b(res_b), .res_gcd(res_gcd), .res_err(res_err),
        .busy(busy), .core_enable_p(core_enable_p), .core_x(core_x), .core_y(core_y),
        .core_a(core_a), .core_b(core_b), .core_gcd(core_gcd), .core_done_p(core_done_p)
    );

    always #5 clk = ~clk;

    // Extended Euclid: g = a*x + b*y
    function automatic void egcd(input longint x, input longint y,
                                 output longint g, output longint a, output longint b);
        longint r0, r1, s0, s1, t0, t1, q, tmp;
        r0 = x; r1 = y; s0 = 1; s1 = 0; t0 = 0; t1 = 1;
        while (r1 != 0) begin
            q = r0 / r1;
            tmp = r0 - q * r1; r0 = r1; r1 = tmp;
            tmp = s0 - q * s1; s0 = s1; s1 = tmp;
            tmp = t0 - q * t1; t0 = t1; t1 = tmp;
        end
        g = r0; a = s0; b = t0;
    endfunction

    // Behavioural engine: reads core_x/core_y live, data-dependent latency, optional hang
    bit eng_hang = 1'b0;
    bit eng_run  = 1'b0;
    int eng_cnt  = 0;
    always @(posedge clk) begin
        longint g, a, b;
        core_done_p <= 1'b0;
        if (core_enable_p) begin
            eng_run <= 1'b1;
            eng_cnt <= 4 + int'(core_x[2:0]);
        end else if (eng_run && !eng_hang) begin
            if (eng_cnt == 0) begin
                egcd(longint'(core_x), longint'(core_y), g, a, b);
                core_a      <= CW'(a);
                core_b      <= CW'(b);
                core_gcd    <= NB'(g);
                core_done_p <= 1'b1;
                eng_run     <= 1'b0;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    typedef struct {
        int     id;
        longint x;
        longint y;
        longint g;
        bit     err;
    } exp_t;

    typedef struct {
        int     id;
        longint x;
        longint y;
        longint g;
        bit     err;
    } vec_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pops   = 0;
    int   en_count = 0;
    int   cyc      = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push_exp(input int id, input longint x, input longint y,
                            input longint g, input bit err);
        exp_t e;
        e.id = id; e.x = x; e.y = y; e.g = g; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic check_result();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_result", 64'(res_id), -1);
            return;
        end
        e = exp_q.pop_front();
        n_pops++;
        chk("res_id", 64'(res_id), e.id);
        chk("res_err", 64'(res_err), 64'(e.err));
        chk("res_gcd", 64'(res_gcd), e.g);
        if (e.err)
            chk("res_ab_zero", 64'(res_a == '0 && res_b == '0), 1);
        else
            chk("bezout", longint'($signed(res_a)) * e.x + longint'($signed(res_b)) * e.y, e.g);
    endtask

    // One clock: consume a handshake about to happen, move to next negedge, bookkeeping
    task automatic tick();
        if (rst_n && res_valid && res_ready) check_result();
        @(negedge clk);
        cyc++;
        if (core_enable_p) en_count++;
        req = req & ~ack;
    endtask

    task automatic drive_req(input int id, input longint x, input longint y);
        x_in[id*NB +: NB] = NB'(x);
        y_in[id*NB +: NB] = NB'(y);
        req[id] = 1'b1;
    endtask

    task automatic wait_results(input int n);
        int target, budget;
        target = n_pops + n;
        budget = 0;
        while (n_pops < target && budget < WAIT_BUDGET) begin
            tick();
            budget++;
        end
        if (n_pops < target) chk("result_timeout", n_pops, target);
    endtask

    // Single request with latency checks on ack, start pulse and zero rejection
    task automatic run_single(input int id, input longint x, input longint y,
                              input longint g, input bit err);
        int e0;
        e0 = en_count;
        push_exp(id, x, y, g, err);
        drive_req(id, x, y);
        tick();
        chk("ack_t1", 64'(ack), 64'(1 << id));
        chk("enable_t1", 64'(core_enable_p), err ? 0 : 1);
        if (err) begin
            tick();
            chk("zero_valid_t2", 64'(res_valid), 1);
        end
        wait_results(1);
        chk("enable_count", en_count - e0, err ? 0 : 1);
    endtask

    vec_t vecs[9];

    initial begin
        int n, e0;
        logic [CW-1:0] h_a, h_b;
        logic [NB-1:0] h_g;
        logic [IDW-1:0] h_id;
        logic h_err;

        vecs[0] = '{0, 49, 28, 7, 1'b0};
        vecs[1] = '{1, 0, 15, 0, 1'b1};
        vecs[2] = '{2, 12, 18, 6, 1'b0};
        vecs[3] = '{3, 100, 75, 25, 1'b0};
        vecs[4] = '{0, 35, 64, 1, 1'b0};
        vecs[5] = '{1, 17, 0, 0, 1'b1};
        vecs[6] = '{2, 65535, 255, 255, 1'b0};
        vecs[7] = '{3, 1, 1, 1, 1'b0};
        vecs[8] = '{0, 48, 36, 12, 1'b0};

        rst_n = 1'b0; req = '0; x_in = '0; y_in = '0; res_ready = 1'b1;
        tick(); tick();
        chk("reset_outputs", 64'(|{ack, res_valid, res_id, res_a, res_b, res_gcd, res_err,
                                   busy, core_enable_p, core_x, core_y}), 0);
        rst_n = 1'b1;
        tick();

        // Single requests, including gcd(49,28) and zero-operand rejection
        for (int i = 0; i < 9; i++)
            run_single(vecs[i].id, vecs[i].x, vecs[i].y, vecs[i].g, vecs[i].err);

        // Pointer now 1 after the last grant to 0; bring it to 0 with a grant to 3
        run_single(3, 20, 8, 4, 1'b0);

        // All four at once: served 0,1,2,3
        e0 = en_count;
        push_exp(0, 21, 6, 3, 1'b0);
        push_exp(1, 81, 27, 27, 1'b0);
        push_exp(2, 13, 7, 1, 1'b0);
        push_exp(3, 1000, 600, 200, 1'b0);
        drive_req(0, 21, 6); drive_req(1, 81, 27); drive_req(2, 13, 7); drive_req(3, 1000, 600);
        wait_results(4);
        chk("rr_enable_count4", en_count - e0, 4);

        // Grant to 1 moves the pointer to 2, so 0 and 2 together come back 2 then 0
        run_single(1, 14, 21, 7, 1'b0);
        e0 = en_count;
        push_exp(2, 9, 12, 3, 1'b0);
        push_exp(0, 30, 45, 15, 1'b0);
        drive_req(0, 30, 45); drive_req(2, 9, 12);
        wait_results(2);
        chk("rr_enable_count2", en_count - e0, 2);

        // Engine hang: timeout, flush restart with x=y=1, error result
        eng_hang = 1'b1;
        push_exp(2, 21, 14, 0, 1'b1);
        drive_req(2, 21, 14);
        tick();
        chk("hang_enable", 64'(core_enable_p), 1);
        n = 0;
        do begin tick(); n++; end
        while (!(core_enable_p && core_x == NB'(1) && core_y == NB'(1)) && n < 3 * TO);
        chk("flush_pulse_delay", n, TO + 1);
        n = 0;
        do begin tick(); n++; end while (!res_valid && n < 3 * TO);
        chk("flush_to_resp", n, TO);
        wait_results(1);
        eng_hang = 1'b0;
        run_single(1, 27, 18, 9, 1'b0);

        // Back-pressure: result held, no new grant while pending
        res_ready = 1'b0;
        push_exp(0, 35, 64, 1, 1'b0);
        push_exp(3, 44, 121, 11, 1'b0);
        drive_req(0, 35, 64);
        n = 0;
        do begin tick(); n++; end while (!res_valid && n < WAIT_BUDGET);
        chk("hold_valid_seen", 64'(res_valid), 1);
        drive_req(3, 44, 121);
        h_a = res_a; h_b = res_b; h_g = res_gcd; h_id = res_id; h_err = res_err;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_stable", 64'(res_valid && busy && ack == '0 && res_a == h_a && res_b == h_b
                                   && res_gcd == h_g && res_id == h_id && res_err == h_err), 1);
        end
        res_ready = 1'b1;
        tick();
        chk("pending_ack_t1", 64'(ack), 0);
        tick();
        chk("pending_ack_t2", 64'(ack), 64'(4'b1000));
        wait_results(1);

        // Reset in the middle of a run, then a normal request
        drive_req(1, 40, 30);
        tick(); tick(); tick();
        chk("midrun_busy", 64'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_outputs", 64'(|{ack, res_valid, res_id, res_a, res_b, res_gcd,
                                          res_err, busy, core_enable_p, core_x, core_y}), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("stale_done_ignored", 64'(res_valid || busy), 0);
        run_single(2, 12, 18, 6, 1'b0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
